// File: rtl/trainer_pkg.sv
// Shared constants and types for the trainer-kit input conditioning slice.
package trainer_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trainer_debounce_cell.sv
// One conditioned channel: two-flop synchroniser, tick-driven debouncer,
// push-to-toggle latch and registered edge pulses.
module trainer_debounce_cell
  import trainer_pkg::*;
#(
  parameter int DB_TICKS = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  sw,
  input  mode_e mode,
  input  logic  clr,
  output logic  level,
  output logic  rise,
  output logic  fall
);

  localparam int                 CNT_W   = cnt_width(DB_TICKS);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_TICKS - 1);

  logic             s1_p0;
  logic             s2_p1;
  logic             stable_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             latch_p2;

  logic             flip;
  logic             stable_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             latch_nxt;
  logic             level_nxt;

  always_comb begin
    flip       = tick && (s2_p1 != stable_p2) && (cnt_p2 == CNT_MAX);
    stable_nxt = flip ? s2_p1 : stable_p2;

    cnt_nxt = cnt_p2;
    if (tick) begin
      if (s2_p1 == stable_p2 || cnt_p2 == CNT_MAX) cnt_nxt = '0;
      else                                         cnt_nxt = cnt_p2 + 1'b1;
    end

    // In direct mode the latch shadows the debounced value so entering
    // toggle mode never changes the visible level.
    if (clr)                       latch_nxt = 1'b0;
    else if (mode == MODE_TOGGLE)  latch_nxt = (flip && s2_p1) ? ~latch_p2 : latch_p2;
    else                           latch_nxt = stable_nxt;

    level_nxt = (mode == MODE_TOGGLE) ? latch_nxt : stable_nxt;
  end

  // p0/p1: synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
    end else begin
      s1_p0 <= sw;
      s2_p1 <= s1_p0;
    end
  end

  // p2: debounce state, latch and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= 1'b0;
      cnt_p2    <= '0;
      latch_p2  <= 1'b0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      stable_p2 <= stable_nxt;
      cnt_p2    <= cnt_nxt;
      latch_p2  <= latch_nxt;
      level     <= level_nxt;
      rise      <= flip &&  s2_p1;
      fall      <= flip && !s2_p1;
    end
  end

endmodule

// File: rtl/trainer_input_conditioner.sv
// Conditions raw switch/button inputs into debounced levels and edge pulses;
// holds the shared debounce tick divider and one cell per channel.
module trainer_input_conditioner
  import trainer_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int TICK_DIV = 1,
  parameter int DB_TICKS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] sw_in,
  input  logic            toggle_en,
  input  logic            clr,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  localparam int               DIV_W   = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_p0;
  logic             tick;
  mode_e            mode;

  assign tick = ena && (div_p0 == DIV_MAX);
  assign mode = toggle_en ? MODE_TOGGLE : MODE_DIRECT;

  // p0: tick divider, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_p0 <= '0;
    end else if (ena) begin
      div_p0 <= tick ? '0 : div_p0 + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    trainer_debounce_cell #(
      .DB_TICKS (DB_TICKS)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .sw    (sw_in[g]),
      .mode  (mode),
      .clr   (clr),
      .level (level[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_trainer_input_conditioner.sv
// Bench for trainer_input_conditioner: hand-derived vector table through a
// scoreboard queue, plus divider, enable-hold and async-reset sequences.
module tb_trainer_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n, ena, toggle_en, clr;
  logic [1:0] sw_in, level, rise, fall;
  logic       ena2, tog2, clr2;
  logic [1:0] sw2, level2, rise2, fall2;

  always #5 clk = ~clk;

  trainer_input_conditioner #(.N_CH(2), .TICK_DIV(1), .DB_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sw_in(sw_in), .toggle_en(toggle_en),
    .clr(clr), .level(level), .rise(rise), .fall(fall)
  );

  trainer_input_conditioner #(.N_CH(2), .TICK_DIV(4), .DB_TICKS(3)) dut_div (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .sw_in(sw2), .toggle_en(tog2),
    .clr(clr2), .level(level2), .rise(rise2), .fall(fall2)
  );

  typedef struct {
    logic       ena;
    logic [1:0] sw;
    logic       tog;
    logic       clr;
    logic [1:0] lvl;
    logic [1:0] rs;
    logic [1:0] fl;
  } vec_t;

  typedef struct {
    logic [1:0] lvl;
    logic [1:0] rs;
    logic [1:0] fl;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input int n, input logic e, input logic [1:0] s, input logic t,
                     input logic c, input logic [1:0] l, input logic [1:0] r,
                     input logic [1:0] f);
    vec_t v;
    v.ena = e; v.sw = s; v.tog = t; v.clr = c; v.lvl = l; v.rs = r; v.fl = f;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: level/rise/fall got %b_%b_%b required %b_%b_%b", nm,
               act[5:4], act[3:2], act[1:0], req[5:4], req[3:2], req[1:0]);
    end
  endtask

  task automatic check_cond(input string nm, input bit ok, input int act);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, outside required range", nm, act);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t x;
    ena = v.ena; sw_in = v.sw; toggle_en = v.tog; clr = v.clr;
    x.lvl = v.lvl; x.rs = v.rs; x.fl = v.fl; x.idx = idx;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    x = exp_q.pop_front();
    check($sformatf("vec%0d", x.idx), {level, rise, fall}, {x.lvl, x.rs, x.fl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t h;
    int   n;
    bit   moved;

    rst_n = 1'b0; ena = 1'b1; sw_in = 2'b11; toggle_en = 1'b0; clr = 1'b0;
    ena2 = 1'b0; sw2 = 2'b00; tog2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", {level, rise, fall}, 6'b0);
    check("reset_hold_div", {level2, rise2, fall2}, 6'b0);

    // reset release with both switches high, then clean fall
    add(4, 1, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 0, 0, 2'b11, 2'b11, 2'b00);
    add(1, 1, 2'b11, 0, 0, 2'b11, 2'b00, 2'b00);
    add(4, 1, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b11);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
    // two-cycle glitch rejected; three-cycle pulse accepted
    add(2, 1, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00);
    add(5, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
    add(3, 1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b10, 2'b10, 2'b00);
    add(2, 1, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
    // toggle mode: three presses on ch1, then clear
    add(4, 1, 2'b10, 1, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 0, 2'b10, 2'b10, 2'b00);
    add(3, 1, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b10, 1, 0, 2'b10, 2'b00, 2'b10);
    add(3, 1, 2'b10, 1, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 0, 2'b00, 2'b10, 2'b00);
    add(3, 1, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 1, 0, 2'b00, 2'b00, 2'b10);
    add(3, 1, 2'b10, 1, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 0, 2'b10, 2'b10, 2'b00);
    add(3, 1, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 0, 2'b10, 2'b00, 2'b10);
    add(1, 1, 2'b00, 1, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00);
    // mode switching with ch0 stable high
    add(4, 1, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 2'b01, 2'b01, 2'b00);
    add(1, 1, 2'b01, 0, 0, 2'b01, 2'b00, 2'b00);
    add(2, 1, 2'b01, 1, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01, 1, 1, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 0, 0, 2'b01, 2'b00, 2'b00);
    // ena low before and during a count; both channels flip together
    add(8, 0, 2'b10, 0, 0, 2'b01, 2'b00, 2'b00);
    add(2, 1, 2'b10, 0, 0, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b10, 0, 0, 2'b10, 2'b10, 2'b01);
    add(1, 1, 2'b10, 0, 0, 2'b10, 2'b00, 2'b00);
    add(3, 1, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00);
    add(8, 0, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00);
    add(4, 1, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 0, 0, 2'b11, 2'b11, 2'b00);
    add(1, 1, 2'b11, 0, 0, 2'b11, 2'b00, 2'b00);

    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], i);

    // async reset two ticks into a falling count
    h = '{ena: 1'b1, sw: 2'b00, tog: 1'b0, clr: 1'b0, lvl: 2'b11, rs: 2'b00, fl: 2'b00};
    for (int k = 0; k < 4; k++) apply(h, 1000 + k);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", {level, rise, fall}, 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    h.lvl = 2'b00;
    for (int k = 0; k < 8; k++) apply(h, 2000 + k);

    // divided tick: latency window, then ena hold mid-count
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; sw2 = 2'b01; ena2 = 1'b1;
    n = 0;
    while (level2[0] !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_cond("div_latency", (n >= 11) && (n <= 14), n);
    check("div_rise", {level2, rise2, fall2}, 6'b01_01_00);

    sw2 = 2'b00;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    ena2 = 1'b0;
    moved = 1'b0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (level2 !== 2'b01 || rise2 !== 2'b00 || fall2 !== 2'b00) moved = 1'b1;
    end
    check_cond("ena_hold", !moved, int'(moved));
    ena2 = 1'b1;
    n = 0;
    while (level2[0] !== 1'b0 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_cond("ena_resume", (n >= 1) && (n <= 12), n);
    check("ena_resume_fall", {level2, rise2, fall2}, 6'b00_00_01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
